sram_1p_rw_sched: RTL and testbench

- Scheduler and sequencer for one single-port RW SRAM macro: 128 entries x 76 bits, bit-granular write mask, 1-cycle registered read latency.
- Shares the single port between one write requester and one read requester using round-robin arbitration.
- Optionally zero-fills the array after reset.
- Owns a 1-entry response hold buffer, so read data survives backpressure. The macro output is only valid in the cycle after a read.

---
 rtl/sram_1p_rw_sched.sv | 133 +++++++++++++
 tb/tb_sram_1p_rw_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1p_rw_sched.sv
// Single-port RW SRAM scheduler: round-robin write/read arbitration, 1-entry response hold buffer.
// Optional post-reset zero-fill of the array is enabled by defining SRAM_1P_RW_SCHED_INIT_CLEAR_EN.
module sram_1p_rw_sched #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int DATA_W = 76
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] w_mask,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("DEPTH must equal 2**ADDR_W");
  end

  logic              run;
  logic              init_done_nxt;
  logic              read_ok;
  logic              cand_w;
  logic              cand_r;
  logic              grant_w;
  logic              grant_r;
  logic              last_w;
  logic              inflight;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;

`ifdef SRAM_1P_RW_SCHED_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_ptr <= init_ptr + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
  end

  assign run           = (state == ST_RUN) && !reset;
  assign init_done_nxt = (state_nxt == ST_RUN);
`else
  assign run           = !reset;
  assign init_done_nxt = 1'b1;
`endif

  // A read may only issue if its response cannot collide with an unconsumed one.
  assign read_ok = !hold_valid && !(inflight && !resp_ready);
  assign cand_w  = run && w_valid;
  assign cand_r  = run && r_valid && read_ok;
  assign grant_w = cand_w && (!cand_r || !last_w);
  assign grant_r = cand_r && (!cand_w || last_w);
  assign w_ready = grant_w;
  assign r_ready = grant_r;

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
`ifdef SRAM_1P_RW_SCHED_INIT_CLEAR_EN
    if (!reset && state == ST_INIT) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_ptr;
      sram_wmask = '1;
    end else
`endif
    if (grant_w) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = w_addr;
      sram_wmask = w_mask;
      sram_wdata = w_data;
    end else if (grant_r) begin
      sram_en   = 1'b1;
      sram_addr = r_addr;
    end
  end

  // Stage boundary: access issue -> macro output cycle / response hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_w     <= 1'b0;
      inflight   <= 1'b0;
      hold_valid <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      if (grant_w || grant_r) last_w <= grant_w;
      inflight  <= grant_r;
      init_done <= init_done_nxt;
      if (inflight && !resp_ready) hold_valid <= 1'b1;
      else if (resp_ready)         hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (inflight && !resp_ready) hold_data <= sram_rdata;
  end

  assign resp_valid = inflight || hold_valid;
  assign resp_data  = hold_valid ? hold_data : (inflight ? sram_rdata : '0);

endmodule

// File: tb/tb_sram_1p_rw_sched.sv
// Bench for sram_1p_rw_sched: macro model plus a transaction-level scoreboard of the port rules.
module tb_sram_1p_rw_sched;
  localparam int AW = 7;
  localparam int DEPTH = 128;
  localparam int DW = 76;

  logic          clock = 1'b0;
  logic          reset;
  logic          w_valid, w_ready, r_valid, r_ready, resp_valid, resp_ready, init_done;
  logic [AW-1:0] w_addr, r_addr, sram_addr;
  logic [DW-1:0] w_data, w_mask, resp_data, sram_wmask, sram_wdata, sram_rdata;
  logic          sram_en, sram_wmode;

  int total = 0;
  int bad = 0;

  sram_1p_rw_sched #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] rnd76();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Macro model: output is garbage except in the cycle after a read.
  logic [DW-1:0] macro_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) macro_mem[i] = rnd76();
  always @(posedge clock) begin
    if (sram_en && sram_wmode)
      macro_mem[sram_addr] <= (macro_mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
    sram_rdata <= (sram_en && !sram_wmode) ? macro_mem[sram_addr] : rnd76();
  end

  // Reference state
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_kn  [DEPTH];
  logic [DW-1:0] q [$];
  logic [DW-1:0] qk [$];
  logic          last_w, fresh, done;
  logic [5:0]    gpat;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [DW-1:0] wm, input logic rv, input logic [AW-1:0] ra,
                     input logic rr);
    logic rok, wc, rc, ew, er;
    w_valid = wv; w_addr = wa; w_data = wd; w_mask = wm;
    r_valid = rv; r_addr = ra; resp_ready = rr;
    #1;
    chk("resp_valid", DW'(resp_valid), DW'(q.size() != 0));
    if (q.size() != 0) chk("resp_data", resp_data & qk[0], q[0] & qk[0]);
    else               chk("resp_data_idle", resp_data, '0);
    chk("init_done", DW'(init_done), DW'(done));
    rok = (q.size() == 0) || (fresh && rr);
    wc  = done && wv;
    rc  = done && rv && rok;
    ew  = wc && (!rc || !last_w);
    er  = rc && (!wc || last_w);
    chk("w_ready", DW'(w_ready), DW'(ew));
    chk("r_ready", DW'(r_ready), DW'(er));
    chk("sram_en", DW'(sram_en), DW'(ew || er));
    if (ew) begin
      chk("wr_mode", DW'(sram_wmode), DW'(1'b1));
      chk("wr_addr", DW'(sram_addr), DW'(wa));
      chk("wr_mask", sram_wmask, wm);
      chk("wr_data", sram_wdata, wd);
    end
    if (er) begin
      chk("rd_mode", DW'(sram_wmode), '0);
      chk("rd_addr", DW'(sram_addr), DW'(ra));
      chk("rd_mask", sram_wmask, '0);
    end
    gpat = {gpat[4:0], w_ready};
    if (q.size() != 0 && rr) begin
      void'(q.pop_front());
      void'(qk.pop_front());
    end
    if (ew) begin
      ref_mem[wa] = (ref_mem[wa] & ~wm) | (wd & wm);
      ref_kn[wa]  = ref_kn[wa] | wm;
    end
    if (er) begin
      q.push_back(ref_mem[ra]);
      qk.push_back(ref_kn[ra]);
    end
    if (ew || er) last_w = ew;
    fresh = er;
    @(posedge clock); #1;
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, '0, '0, '0, 1'b0, '0, rr);
  endtask

  // Called at posedge+1 with reset high; leaves the model ready for traffic.
  task automatic release_reset();
    reset = 1'b0;
    q.delete(); qk.delete();
    last_w = 1'b0; fresh = 1'b0; done = 1'b0;
`ifdef SRAM_1P_RW_SCHED_INIT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      w_valid = 1'b1; r_valid = 1'b1; resp_ready = 1'b1;
      #1;
      chk("init_en", DW'(sram_en && sram_wmode), DW'(1'b1));
      chk("init_addr", DW'(sram_addr), DW'(i));
      chk("init_wdata", sram_wdata, '0);
      chk("init_wmask", sram_wmask, '1);
      chk("init_ready", DW'({w_ready, r_ready}), '0);
      chk("init_done_low", DW'(init_done), '0);
      chk("init_resp_valid", DW'(resp_valid), '0);
      @(posedge clock); #1;
    end
    w_valid = 1'b0; r_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_kn[i]  = '1;
    end
`else
    w_valid = 1'b0; r_valid = 1'b0;
    @(posedge clock); #1;
`endif
    done = 1'b1;
  endtask

  logic [DW-1:0] d12, masked_exp, ones;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_kn[i]  = '0;
    end
    gpat = '0;
    ones = '1;
    reset = 1'b1;
    w_valid = 1'b1; r_valid = 1'b1; resp_ready = 1'b1;
    w_addr = '0; r_addr = '0; w_data = '0; w_mask = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", DW'({w_ready, r_ready}), '0);
    chk("rst_resp_valid", DW'(resp_valid), '0);
    chk("rst_init_done", DW'(init_done), '0);
    chk("rst_sram_en", DW'(sram_en), '0);

    release_reset();

    // Contention straight after reset: write must win first.
    d12 = rnd76();
    for (int i = 0; i < 6; i++) cyc(1'b1, 7'h20, d12, ones, 1'b1, 7'h20, 1'b1);
    chk("contention_pattern", DW'(gpat), DW'(6'b101010));
    idle(1'b1); idle(1'b1);

`ifdef SRAM_1P_RW_SCHED_INIT_CLEAR_EN
    cyc(1'b0, '0, '0, '0, 1'b1, 7'd5, 1'b1);
    #1;
    chk("cleared_addr5", resp_data, '0);
    idle(1'b1);
`endif

    // Write then read the same address on consecutive cycles.
    d12 = 76'h0_DEAD_BEEF_0000_0001;
    cyc(1'b1, 7'h12, d12, ones, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b1, 7'h12, 1'b1);
    #1;
    chk("wr_rd_data", resp_data, d12);
    idle(1'b1);

    // Masked write over an all-ones entry.
    cyc(1'b1, 7'd3, ones, ones, 1'b0, '0, 1'b1);
    cyc(1'b1, 7'd3, '0, DW'(8'hFF), 1'b0, '0, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b1, 7'd3, 1'b1);
    masked_exp = {ones[DW-1:8], 8'h00};
    #1;
    chk("masked_data", resp_data, masked_exp);
    idle(1'b1);

    // Backpressure: held data must survive an overwrite of its address.
    cyc(1'b0, '0, '0, '0, 1'b1, 7'h12, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 7'h12, rnd76(), ones, 1'b1, 7'h12, 1'b0);
      chk("held_data", resp_data, d12);
    end
    cyc(1'b0, '0, '0, '0, 1'b1, 7'h12, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b1, 7'h12, 1'b1);
    idle(1'b1); idle(1'b1);

    // Randomized traffic over a small address window.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rnd76(),
          (i % 3 == 0) ? ones : rnd76(),
          1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
          ($urandom_range(0, 3) != 0));
    idle(1'b1); idle(1'b1);

    // Reset while a read response is in flight.
    cyc(1'b0, '0, '0, '0, 1'b1, 7'h12, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_resp_valid", DW'(resp_valid), '0);
    chk("midrst_sram_en", DW'(sram_en), '0);
    chk("midrst_init_done", DW'(init_done), '0);
    @(posedge clock); #1;
    chk("midrst_hold_resp_valid", DW'(resp_valid), '0);
    release_reset();
    for (int i = 0; i < 4; i++) idle(1'b0);
    cyc(1'b1, 7'h40, d12, ones, 1'b1, 7'h40, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b1, 7'h40, 1'b1);
    idle(1'b1); idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
